// File: rtl/window_avg_pkg.sv
// Shared constants and arithmetic helpers for the window averager.
// Helpers work on 64-bit values; callers size-cast the results back down.
package window_avg_pkg;

  localparam logic MODE_BLOCK = 1'b0;
  localparam logic MODE_SLIDE = 1'b1;

  function automatic logic [63:0] abs_diff(input logic [63:0] a, input logic [63:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Divide by 2^log_n, optionally rounding half up; log_n is at least 1.
  function automatic logic [63:0] mean_of(input logic [63:0] s, input int unsigned log_n,
                                          input logic rnd);
    if (rnd)
      return (s + (64'd1 << (log_n - 1))) >> log_n;
    return s >> log_n;
  endfunction

endpackage

// File: rtl/avg_ring_buf.sv
// N-deep circular sample store; the slot about to be overwritten is the oldest sample.
module avg_ring_buf import window_avg_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int LOG_N  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] oldest
);

  localparam int N = 1 << LOG_N;

  logic [DATA_W-1:0] mem [N];
  logic [LOG_N-1:0]  wr_ptr;
  logic [LOG_N-1:0]  wr_idx;

  // A clear with a simultaneous write restarts the ring at slot 0.
  assign wr_idx = clear ? '0 : wr_ptr;
  assign oldest = mem[wr_ptr];

  always_ff @(posedge clk) begin
    if (rst)
      wr_ptr <= '0;
    else if (wr_en)
      wr_ptr <= wr_idx + LOG_N'(1);
    else if (clear)
      wr_ptr <= '0;
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst)
      mem[wr_idx] <= wr_data;
  end

endmodule

// File: rtl/window_averager.sv
// Block or sliding mean over 2^LOG_N samples, plus |mean - closing sample|.
// Results are registered and appear one cycle after the closing sample.
module window_averager import window_avg_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int LOG_N  = 2,
  parameter int ROUND  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              mode,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] avg_out,
  output logic [DATA_W-1:0] diff_out,
  output logic              done
);

  localparam int SUM_W = DATA_W + LOG_N;
  localparam int N     = 1 << LOG_N;
  localparam logic [LOG_N-1:0] LAST = LOG_N'(N - 1);

  logic [SUM_W-1:0]  sum, sum_next, window_sum, new_ext, old_ext;
  logic [LOG_N-1:0]  count, count_next;
  logic              primed, primed_next, mode_q, clear, closing;
  logic [DATA_W-1:0] oldest, avg_next, diff_next;

  // A mode switch discards the partial window exactly like a flush.
  assign clear   = flush || (mode != mode_q);
  assign new_ext = SUM_W'(in_data);
  assign old_ext = SUM_W'(oldest);

  avg_ring_buf #(
    .DATA_W (DATA_W),
    .LOG_N  (LOG_N)
  ) u_ring (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .wr_en   (in_valid),
    .wr_data (in_data),
    .oldest  (oldest)
  );

  always_comb begin
    sum_next    = sum;
    count_next  = count;
    primed_next = primed;
    closing     = 1'b0;
    window_sum  = sum + new_ext;
    if (clear) begin
      sum_next    = in_valid ? new_ext : '0;
      count_next  = in_valid ? LOG_N'(1) : '0;
      primed_next = 1'b0;
    end else if (in_valid) begin
      if (mode_q == MODE_BLOCK) begin
        if (count == LAST) begin
          closing    = 1'b1;
          sum_next   = '0;
          count_next = '0;
        end else begin
          sum_next   = window_sum;
          count_next = count + LOG_N'(1);
        end
      end else if (primed) begin
        // The oldest sample is still inside sum, so this cannot underflow.
        window_sum = sum + new_ext - old_ext;
        sum_next   = window_sum;
        closing    = 1'b1;
      end else begin
        sum_next = window_sum;
        if (count == LAST) begin
          primed_next = 1'b1;
          count_next  = '0;
          closing     = 1'b1;
        end else begin
          count_next = count + LOG_N'(1);
        end
      end
    end
    avg_next  = DATA_W'(mean_of(64'(window_sum), LOG_N, ROUND != 0));
    diff_next = DATA_W'(abs_diff(64'(avg_next), 64'(in_data)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      count     <= '0;
      primed    <= 1'b0;
      mode_q    <= mode;
      out_valid <= 1'b0;
      avg_out   <= '0;
      diff_out  <= '0;
    end else begin
      sum       <= sum_next;
      count     <= count_next;
      primed    <= primed_next;
      mode_q    <= mode;
      out_valid <= closing;
      if (closing) begin
        avg_out  <= avg_next;
        diff_out <= diff_next;
      end
    end
  end

  assign done = (mode_q == MODE_BLOCK) ? (count == '0) : primed;

endmodule

// File: tb/tb_window_averager.sv
// Drives a truncating and a rounding averager with the same stream and compares
// both against a queue-based model of the window arithmetic.
module tb_window_averager;

  localparam int N = 4;

  logic       clk;
  logic       rst, in_valid, mode, flush;
  logic [7:0] in_data;
  logic       out_valid0, out_valid1, done0, done1;
  logic [7:0] avg0, avg1, diff0, diff1;

  int checks = 0;
  int errors = 0;

  int win[$];
  logic modeQ;
  int expValid;
  int expAvg[2];
  int expDiff[2];

  window_averager #(.DATA_W(8), .LOG_N(2), .ROUND(0)) dutTrunc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .mode(mode),
    .flush(flush), .out_valid(out_valid0), .avg_out(avg0), .diff_out(diff0), .done(done0)
  );

  window_averager #(.DATA_W(8), .LOG_N(2), .ROUND(1)) dutRound (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .mode(mode),
    .flush(flush), .out_valid(out_valid1), .avg_out(avg1), .diff_out(diff1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Model: a queue of the samples in the current window.
  task automatic modelStep(input logic v, input int d, input logic m, input logic f, input logic r);
    int s;
    if (r) begin
      win.delete();
      modeQ = m;
      expValid = 0;
      for (int k = 0; k < 2; k++) begin
        expAvg[k] = 0;
        expDiff[k] = 0;
      end
      return;
    end
    expValid = 0;
    if (f || (m != modeQ)) win.delete();
    modeQ = m;
    if (v) begin
      win.push_back(d);
      if (modeQ == 1'b1 && win.size() > N) void'(win.pop_front());
      if (win.size() == N) begin
        s = 0;
        foreach (win[i]) s += win[i];
        expValid = 1;
        expAvg[0] = s / N;
        expAvg[1] = (s + N / 2) / N;
        for (int k = 0; k < 2; k++)
          expDiff[k] = (expAvg[k] >= d) ? expAvg[k] - d : d - expAvg[k];
        if (modeQ == 1'b0) win.delete();
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input int d, input logic m, input logic f, input logic r);
    int expDone;
    @(negedge clk);
    in_valid = v;
    in_data  = 8'(d);
    mode     = m;
    flush    = f;
    rst      = r;
    @(posedge clk);
    #1;
    modelStep(v, d, m, f, r);
    expDone = (modeQ == 1'b0) ? int'(win.size() == 0) : int'(win.size() == N);
    checkOutput("valid_t", int'(out_valid0), expValid);
    checkOutput("valid_r", int'(out_valid1), expValid);
    checkOutput("avg_t", int'(avg0), expAvg[0]);
    checkOutput("avg_r", int'(avg1), expAvg[1]);
    checkOutput("diff_t", int'(diff0), expDiff[0]);
    checkOutput("diff_r", int'(diff1), expDiff[1]);
    checkOutput("done_t", int'(done0), expDone);
    checkOutput("done_r", int'(done1), expDone);
  endtask

  task automatic sendBlock(input int a, input int b, input int c, input int e, input int gap);
    int vals[4];
    vals = '{a, b, c, e};
    foreach (vals[i]) begin
      applyStimulus(1'b1, vals[i], 1'b0, 1'b0, 1'b0);
      if (i != 3)
        for (int g = 0; g < gap; g++) applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic curMode;
    logic v, f, r;
    int d;
    in_valid = 1'b0;
    in_data  = 8'd0;
    mode     = 1'b0;
    flush    = 1'b0;
    rst      = 1'b1;

    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
    checkOutput("reset_done", int'(done0), 1);
    checkOutput("reset_avg", int'(avg0), 0);

    // Block mode, back to back and with idle gaps.
    sendBlock(10, 20, 30, 44, 0);
    checkOutput("tp_avg", int'(avg0), 26);
    checkOutput("tp_diff", int'(diff0), 18);
    checkOutput("tp_done", int'(done0), 1);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("tp_idle", int'(out_valid0), 0);
    sendBlock(10, 20, 30, 44, 2);
    checkOutput("gap_avg", int'(avg0), 26);

    // Saturation and rounding.
    sendBlock(255, 255, 255, 255, 0);
    checkOutput("sat_avg_t", int'(avg0), 255);
    checkOutput("sat_avg_r", int'(avg1), 255);
    sendBlock(1, 1, 1, 0, 0);
    checkOutput("rnd_avg_t", int'(avg0), 0);
    checkOutput("rnd_avg_r", int'(avg1), 1);
    checkOutput("rnd_diff_r", int'(diff1), 1);

    // Sliding mode.
    applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 4 * i, 1'b1, 1'b0, 1'b0);
    checkOutput("sl_avg1", int'(avg0), 10);
    checkOutput("sl_diff1", int'(diff0), 6);
    checkOutput("sl_done", int'(done0), 1);
    applyStimulus(1'b1, 20, 1'b1, 1'b0, 1'b0);
    checkOutput("sl_avg2", int'(avg0), 14);

    // Flush with data, then reset mid-window.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 50, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 100, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 100, 1'b0, 1'b0, 1'b0);
    checkOutput("fl_pulse", int'(out_valid0), 1);
    checkOutput("fl_avg", int'(avg0), 100);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 50, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 50, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_avg", int'(avg0), 0);
    checkOutput("rst_valid", int'(out_valid0), 0);
    applyStimulus(1'b1, 50, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_nopulse", int'(out_valid0), 0);

    // Random traffic with occasional flushes, mode switches and resets.
    curMode = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 59) == 0) curMode = ~curMode;
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 39) == 0);
      r = ($urandom_range(0, 249) == 0);
      case ($urandom_range(0, 7))
        0:       d = 0;
        1:       d = 255;
        default: d = int'($urandom_range(0, 255));
      endcase
      applyStimulus(v, d, curMode, f, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
